// File: rtl/fp_norm_pkg.sv
// Shared definitions for the small-float normalise/round pipeline.
package fp_norm_pkg;

  // Rounding mode encodings carried with each beat
  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  // Result flags; at most one is set for a valid beat
  typedef struct packed {
    logic zero;
    logic ovf;
    logic uf;
  } fp_flags_t;

  // Input sum width: carry + mantissa (with leading one) + guard bits
  function automatic int sw(input int mw, input int gw);
    return mw + 1 + gw;
  endfunction

endpackage

// File: rtl/fp_norm_lzc.sv
// Combinational leading-zero counter; returns W for an all-zero input.
module fp_norm_lzc #(
  parameter int W  = 5,
  parameter int ZW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_val,
  output logic [ZW-1:0] o_cnt
);

  logic w_found;

  // Scan from the MSB; the first set bit fixes the count
  always_comb begin
    o_cnt   = ZW'(W);
    w_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!w_found && i_val[i]) begin
        o_cnt   = ZW'(W - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Three-stage normalise/round stage: sign resolve, LZC normalise, round and
// flag resolution. One global advance signal stalls all stages together.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int EW = 3,
  parameter int MW = 2,
  parameter int GW = 2,
  localparam int SW = sw(MW, GW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_sum,
  input  logic [EW-1:0] in_exp,
  input  logic          in_sub,
  input  logic          in_sel,
  input  logic          in_sa,
  input  logic          in_sb,
  input  logic          rnd_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW-1:0] out_mant,
  output logic          out_zero,
  output logic          out_ovf,
  output logic          out_uf
);

  localparam int ZW = $clog2(SW + 1);
  // Signed exponent width: room for +1 on carry, +1 on rounding and -SW
  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] EMAX  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] EZERO = '0;

  logic w_adv;

  // Stage 1 registers
  logic                 r1_v;
  logic [SW-1:0]        r1_mag;
  logic                 r1_sign;
  logic [EW-1:0]        r1_exp;
  logic                 r1_rnd;

  // Stage 2 registers
  logic                 r2_v;
  logic [SW-1:0]        r2_norm;
  logic signed [XW-1:0] r2_e;
  logic                 r2_sign;
  logic                 r2_rnd;
  logic                 r2_zero;
  logic                 r2_uf;

  // Stage 3 (output) registers
  logic                 r3_v;
  logic                 r3_sign;
  logic [EW-1:0]        r3_exp;
  logic [MW-1:0]        r3_mant;
  fp_flags_t            r3_flags;

  // Stage 1 combinational
  logic                 w_neg;
  logic [SW-1:0]        w_mag;
  logic                 w_sign;

  // Stage 2 combinational
  logic [ZW-1:0]        w_z;
  logic [SW-1:0]        w_norm;
  logic signed [XW-1:0] w_e;
  logic                 w_zero;
  logic                 w_uf;

  // Stage 3 combinational
  logic [MW-1:0]        w_mant_t;
  logic                 w_rbit;
  logic                 w_sbit;
  logic                 w_inc;
  logic [MW:0]          w_mant_sum;
  logic [MW-1:0]        w_mant_r;
  logic signed [XW-1:0] w_e_r;
  logic                 w_ovf;
  logic                 w_res_sign;
  logic [EW-1:0]        w_res_exp;
  logic [MW-1:0]        w_res_mant;
  fp_flags_t            w_res_flags;

  assign w_adv    = !r3_v || out_ready;
  assign in_ready = w_adv;

  // Resolve effective-subtraction sign and take the magnitude
  always_comb begin
    w_neg  = in_sub & in_sum[SW-1];
    w_mag  = w_neg ? (~in_sum + SW'(1)) : in_sum;
    w_sign = (in_sel ? in_sa : in_sb) ^ w_neg;
  end

  fp_norm_lzc #(
    .W  (SW),
    .ZW (ZW)
  ) u_lzc (
    .i_val (r1_mag),
    .o_cnt (w_z)
  );

  // Normalise: shift out leading zeros; a carry (z=0) bumps the exponent
  always_comb begin
    w_norm = r1_mag << w_z;
    w_e    = XW'(r1_exp) + XW'(1) - XW'(w_z);
    w_zero = (r1_mag == '0);
    w_uf   = !w_zero && (w_e <= EZERO);
  end

  // Round and resolve flags with priority zero > underflow > overflow
  always_comb begin
    w_mant_t   = w_norm_top(r2_norm);
    w_rbit     = r2_norm[GW];
    w_sbit     = |r2_norm[GW-1:0];
    w_inc      = (r2_rnd == RND_RNE) && w_rbit && (w_sbit || w_mant_t[0]);
    w_mant_sum = {1'b0, w_mant_t} + (MW+1)'(w_inc);
    w_mant_r   = w_mant_sum[MW] ? {1'b1, {(MW-1){1'b0}}} : w_mant_sum[MW-1:0];
    w_e_r      = r2_e + XW'(w_mant_sum[MW]);
    w_ovf      = (w_e_r > EMAX);

    w_res_sign  = 1'b0;
    w_res_exp   = '0;
    w_res_mant  = '0;
    w_res_flags = '0;
    if (r2_v) begin
      if (r2_zero) begin
        w_res_flags.zero = 1'b1;
      end else if (r2_uf) begin
        w_res_flags.uf = 1'b1;
      end else if (w_ovf) begin
        w_res_sign      = r2_sign;
        w_res_exp       = '1;
        w_res_mant      = '1;
        w_res_flags.ovf = 1'b1;
      end else begin
        w_res_sign = r2_sign;
        w_res_exp  = w_e_r[EW-1:0];
        w_res_mant = w_mant_r;
      end
    end
  end

  function automatic logic [MW-1:0] w_norm_top(input logic [SW-1:0] n);
    return n[SW-1 -: MW];
  endfunction

  // Pipeline registers; every stage holds while the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_v     <= 1'b0;
      r1_mag   <= '0;
      r1_sign  <= 1'b0;
      r1_exp   <= '0;
      r1_rnd   <= 1'b0;
      r2_v     <= 1'b0;
      r2_norm  <= '0;
      r2_e     <= '0;
      r2_sign  <= 1'b0;
      r2_rnd   <= 1'b0;
      r2_zero  <= 1'b0;
      r2_uf    <= 1'b0;
      r3_v     <= 1'b0;
      r3_sign  <= 1'b0;
      r3_exp   <= '0;
      r3_mant  <= '0;
      r3_flags <= '0;
    end else if (w_adv) begin
      r1_v     <= in_valid;
      r1_mag   <= w_mag;
      r1_sign  <= w_sign;
      r1_exp   <= in_exp;
      r1_rnd   <= rnd_mode;
      r2_v     <= r1_v;
      r2_norm  <= w_norm;
      r2_e     <= w_e;
      r2_sign  <= r1_sign;
      r2_rnd   <= r1_rnd;
      r2_zero  <= w_zero;
      r2_uf    <= w_uf;
      r3_v     <= r2_v;
      r3_sign  <= w_res_sign;
      r3_exp   <= w_res_exp;
      r3_mant  <= w_res_mant;
      r3_flags <= w_res_flags;
    end
  end

  assign out_valid = r3_v;
  assign out_sign  = r3_sign;
  assign out_exp   = r3_exp;
  assign out_mant  = r3_mant;
  assign out_zero  = r3_flags.zero;
  assign out_ovf   = r3_flags.ovf;
  assign out_uf    = r3_flags.uf;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Self-checking bench for fp_normalize_pipe at EW=3, MW=2, GW=2.
module tb_fp_normalize_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_sum;
  logic [2:0] in_exp;
  logic       in_sub, in_sel, in_sa, in_sb, rnd_mode;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [2:0] out_exp;
  logic [1:0] out_mant;
  logic       out_zero, out_ovf, out_uf;

  int n_cmp = 0;
  int n_bad = 0;

  fp_normalize_pipe #(.EW(3), .MW(2), .GW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_exp    (in_exp),
    .in_sub    (in_sub),
    .in_sel    (in_sel),
    .in_sa     (in_sa),
    .in_sb     (in_sb),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_uf    (out_uf)
  );

  always #5 clk = ~clk;

  // Result packed as {sign, exp[2:0], mant[1:0], zero, ovf, uf}
  function automatic logic [8:0] get_out();
    return {out_sign, out_exp, out_mant, out_zero, out_ovf, out_uf};
  endfunction

  // Reference: treat the sum as a number, normalise by doubling until the
  // top bit of a 5-bit field is reached, then round on the remainder.
  function automatic logic [8:0] ref_model(input logic [4:0] s, input logic [2:0] ex,
                                           input logic sub, input logic sel,
                                           input logic sa, input logic sb, input logic rnd);
    int v, mag, n, z, e, mant, rem, sgn;
    bit neg;
    v   = int'(s);
    neg = sub && (v >= 16);
    mag = neg ? (32 - v) % 32 : v;
    if (neg) mag = (mag == 0) ? 16 : mag;
    sgn = int'(sel ? sa : sb) ^ int'(neg);
    if (mag == 0) return 9'b0_000_00_100;
    n = mag; z = 0;
    while (n < 16) begin n = n * 2; z++; end
    e = int'(ex) + 1 - z;
    if (e <= 0) return 9'b0_000_00_001;
    mant = n / 8;
    rem  = n % 8;
    if (rnd && (rem > 4 || (rem == 4 && (mant % 2) == 1))) mant++;
    if (mant == 4) begin mant = 2; e++; end
    if (e > 7) return {sgn[0], 3'b111, 2'b11, 3'b010};
    return {sgn[0], 3'(e), 2'(mant), 3'b000};
  endfunction

  task automatic set_beat(input logic v, input logic [4:0] s, input logic [2:0] ex,
                          input logic sub, input logic sel, input logic sa,
                          input logic sb, input logic rnd);
    in_valid = v; in_sum = s; in_exp = ex; in_sub = sub;
    in_sel = sel; in_sa = sa; in_sb = sb; rnd_mode = rnd;
  endtask

  task automatic rand_beat(input logic v);
    set_beat(v, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    set_beat(1'b0, '0, '0, 0, 0, 0, 0, fp_norm_pkg::RND_TRUNC);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, get_out()} !== 10'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0", {out_valid, get_out()});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [4:0] s [11];
    logic [2:0] ex [11];
    logic [6:0] ctl [11];   // {sub, sel, sa, sb, rnd, 2'b0}
    logic [8:0] want [11];
    int k;
    s    = '{5'b01100, 5'b01010, 5'b10110, 5'b10110, 5'b01110, 5'b11010,
             5'b00000, 5'b00001, 5'b11100, 5'b01111, 5'b01111};
    ex   = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd7, 3'd7, 3'd7};
    ctl  = '{7'b00001_00, 7'b00001_00, 7'b00001_00, 7'b00000_00, 7'b00001_00,
             7'b11011_00, 7'b00011_00, 7'b00011_00, 7'b00011_00, 7'b00001_00,
             7'b00000_00};
    want = '{9'b0_011_11_000, 9'b0_011_10_000, 9'b0_100_11_000, 9'b0_100_10_000,
             9'b0_100_10_000, 9'b1_010_11_000, 9'b0_000_00_100, 9'b0_000_00_001,
             9'b1_111_11_010, 9'b0_111_11_010, 9'b0_111_11_000};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      set_beat(1'b1, s[i], ex[i], ctl[i][6], ctl[i][5], ctl[i][4], ctl[i][3], ctl[i][2]);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      k = 1;
      while (k <= 6) begin
        @(negedge clk);
        if (out_valid) break;
        k++;
      end
      n_cmp++;
      if (k != 3) begin
        n_bad++; $display("FAIL latency case %0d: got %0d cycles want 3", i, k);
      end
      n_cmp++;
      if (get_out() !== want[i]) begin
        n_bad++; $display("FAIL directed case %0d: got %b want %b", i, get_out(), want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] q[$];
    logic [8:0] held, got, exp_v;
    logic held_v;
    held_v = 1'b0;
    held = '0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      if (c < 390) begin
        rand_beat(1'($urandom_range(0, 9) < 7));
        out_ready = 1'($urandom_range(0, 9) < 7);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      got = get_out();
      if (held_v) begin
        n_cmp++;
        if (!out_valid || got !== held) begin
          n_bad++; $display("FAIL stall_hold: got v=%b %b want v=1 %b", out_valid, got, held);
        end
      end
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_bad++; $display("FAIL in_ready_rule: got %b want %b", in_ready, !out_valid || out_ready);
      end
      if (!out_valid) begin
        n_cmp++;
        if ({out_zero, out_ovf, out_uf} !== 3'b000) begin
          n_bad++; $display("FAIL idle_flags: got %b want 000", {out_zero, out_ovf, out_uf});
        end
      end
      if (in_valid && in_ready)
        q.push_back(ref_model(in_sum, in_exp, in_sub, in_sel, in_sa, in_sb, rnd_mode));
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL random_spurious: got %b want no beat", got);
        end else begin
          exp_v = q.pop_front();
          if (got !== exp_v) begin
            n_bad++; $display("FAIL random_result: got %b want %b", got, exp_v);
          end
        end
      end
      held_v = out_valid && !out_ready;
      held   = got;
      @(posedge clk);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL random_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] q[$];
    logic [8:0] exp_v;
    int acc, got_n;
    logic want_rdy;
    acc = 0;
    got_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      want_rdy = !(c >= 4 && c <= 6);
      out_ready = want_rdy;
      if (acc < 8) rand_beat(1'b1);
      else in_valid = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== want_rdy) begin
        n_bad++; $display("FAIL b2b_in_ready cycle %0d: got %b want %b", c, in_ready, want_rdy);
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_sum, in_exp, in_sub, in_sel, in_sa, in_sb, rnd_mode));
        acc++;
      end
      if (out_valid && out_ready) begin
        got_n++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL b2b_spurious: got %b want no beat", get_out());
        end else begin
          exp_v = q.pop_front();
          if (get_out() !== exp_v) begin
            n_bad++; $display("FAIL b2b_result %0d: got %b want %b", got_n, get_out(), exp_v);
          end
        end
      end
      @(posedge clk);
    end
    n_cmp++;
    if (got_n != 8 || acc != 8) begin
      n_bad++; $display("FAIL b2b_count: got %0d out / %0d in want 8 / 8", got_n, acc);
    end
  endtask

  task automatic test_reset_in_flight();
    logic seen;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      rand_beat(1'b1);
      @(posedge clk);
    end
    #2;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL flight_prefill: got out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, get_out()} !== 10'b0) begin
      n_bad++; $display("FAIL flight_reset_outputs: got %b want 0", {out_valid, get_out()});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL flight_stale_beat: got out_valid=1 want 0");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
